// File: rtl/rst_seq_sync.sv
// Reset sequencer: synchronises the async rst_n release, then releases NUM_OUT
// active-low reset channels in order, with a timed soft-reset hold.
module rst_seq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int SOFT_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done,
    output logic               soft_busy
);

    localparam int MAX_CYC = (GAP_CYCLES > SOFT_CYCLES) ? GAP_CYCLES : SOFT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_OUT + 1);

    // The gap counter is reloaded one short: the expiry edge itself is the last gap edge.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ALL   = IDX_W'(NUM_OUT);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2,
        SOFT    = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_rst_n;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUT-1:0]     rst_out_n_q, rst_out_n_d;
    logic                   rst_done_q, rst_done_d;
    logic                   soft_busy_q, soft_busy_d;

    // Thermometer code: channels below the released count are high.
    function automatic logic [NUM_OUT-1:0] released_mask(input logic [IDX_W-1:0] count);
        logic [NUM_OUT-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            mask[i] = (IDX_W'(i) < count);
        end
        return mask;
    endfunction

    // Synchroniser shift input: constant one entering the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Next-state, shared counter and channel index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            HOLD: begin
                if (sync_rst_n) begin
                    idx_d = IDX_ONE;
                    cnt_d = GAP_LOAD;
                    if (NUM_OUT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    idx_d = '0;
                    cnt_d = '0;
                end
            end
            RELEASE: begin
                if (soft_rst_req) begin
                    state_d = SOFT;
                    idx_d   = '0;
                    cnt_d   = SOFT_LOAD;
                end else if (cnt_q == '0) begin
                    idx_d = idx_q + IDX_ONE;
                    if ((idx_q + IDX_ONE) == IDX_ALL) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (soft_rst_req) begin
                    state_d = SOFT;
                    idx_d   = '0;
                    cnt_d   = SOFT_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            SOFT: begin
                if (soft_rst_req) begin
                    cnt_d = SOFT_LOAD;
                end else if (cnt_q == '0) begin
                    idx_d = IDX_ONE;
                    cnt_d = GAP_LOAD;
                    if (NUM_OUT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge.
    always_comb begin
        rst_out_n_d = released_mask(idx_d);
        rst_done_d  = (state_d == DONE);
        soft_busy_d = (state_d == SOFT);
    end

    // State, counter, index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_n_q <= '0;
            rst_done_q  <= 1'b0;
            soft_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_n_q <= rst_out_n_d;
            rst_done_q  <= rst_done_d;
            soft_busy_q <= soft_busy_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_done  = rst_done_q;
    assign soft_busy = soft_busy_q;

endmodule

// File: doc/rst_seq_sync.md
RST_SEQ_SYNC -- requirements
Module: rst_seq_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops; legal range 2..8.
REQ-002 SHALL have parameter NUM_OUT, default 4, number of sequenced reset output channels; legal range 1..16.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, clk cycles between successive channel releases; legal range 1..65535.
REQ-004 SHALL have parameter SOFT_CYCLES, default 8, clk cycles all outputs are held low after a soft reset request; legal range 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all sequential logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port soft_rst_req, input, 1 bit: synchronous soft reset request, level-sampled each edge.
REQ-008 SHALL have port rst_out_n, output, NUM_OUT bits: per-channel active-low resets, released in order from bit 0 upward.
REQ-009 SHALL have port rst_done, output, 1 bit: high when every channel is released.
REQ-010 SHALL have port soft_busy, output, 1 bit: high while a soft reset hold is in progress.

Function
REQ-011 SHALL implement a SYNC_STAGES-deep flop chain, async-cleared by rst_n, with a constant 1 input; sync_rst_n is the last stage.
REQ-012 SHALL implement an FSM with states HOLD, RELEASE, DONE and SOFT, plus one shared down-counter of width clog2(max(GAP_CYCLES,SOFT_CYCLES)+1) and a channel index of width clog2(NUM_OUT+1).
REQ-013 HOLD: all rst_out_n low; when sync_rst_n is high, SHALL move to RELEASE on that edge with rst_out_n[0] rising on the same edge, i.e. SYNC_STAGES+1 edges after rst_n deasserts.
REQ-014 RELEASE: rst_out_n[i] SHALL rise exactly GAP_CYCLES edges after rst_out_n[i-1]; released channels stay high.
REQ-015 RELEASE: on the edge channel NUM_OUT-1 rises, the FSM SHALL enter DONE and rst_done SHALL rise on that same edge.
REQ-016 NUM_OUT=1: SHALL go straight from HOLD to DONE, with rst_out_n[0] and rst_done rising together.
REQ-017 DONE and RELEASE: soft_rst_req high at an edge SHALL drive all rst_out_n low and rst_done low, set soft_busy high, and enter SOFT with the counter loaded to SOFT_CYCLES, all on that edge.
REQ-018 SOFT: on the edge where the counter expires, the FSM SHALL enter RELEASE with rst_out_n[0] rising and soft_busy falling; that edge is SOFT_CYCLES+1 edges after the request edge.
REQ-019 SOFT: soft_rst_req high SHALL reload the counter to SOFT_CYCLES, extending the hold.
REQ-020 HOLD: soft_rst_req SHALL be ignored.
REQ-021 Outputs are registered with no combinational path from soft_rst_req to any output.
REQ-022 soft_busy is high only in SOFT; rst_done is high only in DONE.

Reset
REQ-023 rst_n low SHALL asynchronously clear the synchronizer, force all rst_out_n=0, rst_done=0 and soft_busy=0, and force the FSM to HOLD with counter and index at 0, without waiting for clk.
REQ-024 rst_n asserted mid-RELEASE or mid-SOFT SHALL abort the sequence; after rst_n deasserts, the full sequence restarts from channel 0 per REQ-013.
REQ-025 A rst_n low pulse shorter than one clk period SHALL still produce the full assert and resynchronised release.

Verification (defaults: SYNC_STAGES=2, NUM_OUT=4, GAP_CYCLES=16, SOFT_CYCLES=8; edge 1 is the first rising edge after rst_n rises)
REQ-026 Power-on: rst_n low 5 cycles, then high -> rst_out_n=4'b0000 until edge 3; bit0 at edge 3, bit1 at 19, bit2 at 35, bit3 and rst_done at 51.
REQ-027 Async assert: in DONE, drop rst_n mid-cycle -> rst_out_n=0 and rst_done=0 before the next clk edge; release repeats the REQ-026 timing.
REQ-028 Soft reset: in DONE, soft_rst_req high for 1 cycle at edge E -> outputs 0 and soft_busy=1 after E; rst_out_n[0] rises and soft_busy falls at E+9; rst_done rises at E+57.
REQ-029 Soft extend: second request at E+5 -> rst_out_n[0] rises at E+14; a request during HOLD (before edge 3) has no effect.
REQ-030 Soft during RELEASE: request at edge 25 (bits 0-1 high) -> all bits 0 after edge 25; bit0 rises at edge 34.
REQ-031 Parameter sweep: NUM_OUT=1, GAP_CYCLES=1, SYNC_STAGES=3 -> rst_out_n[0] and rst_done rise together at edge 4.
